// File: rtl/alu_issue_wb.sv
// alu_issue_wb: instruction issue and writeback around an external registered ALU.
// Decodes 32-bit instructions from a valid/ready stream. Operands come from an
// internal register file, with a forward path from the writeback stage. The block
// drives the ALU inputs for one cycle per issued instruction and later writes the
// ALU result back to the register file. It also stalls on hazards and keeps
// retire and drop counters.
module alu_issue_wb #(
    parameter int N    = 32,
    parameter int S    = 5,
    parameter int NREG = 32,
    parameter int RCW  = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         instr_in,
    input  logic                instr_valid,
    output logic                instr_ready,
    output logic signed [N-1:0] aluin1,
    output logic signed [N-1:0] aluin2,
    output logic [2:0]          aluopselect,
    output logic [2:0]          aluoperation,
    output logic                enable,
    input  logic signed [N:0]   aluout,
    input  logic                enable_arith_out,
    input  logic [S-1:0]        dbg_raddr,
    output logic [N-1:0]        dbg_rdata,
    output logic [RCW-1:0]      retire_count,
    output logic [7:0]          drop_count,
    output logic                busy
);

    typedef enum logic [2:0] {
        OPS_ARITH = 3'b001,
        OPS_MEMRD = 3'b101
    } opsel_e;

    // Decoded fields of the presented instruction
    logic [2:0]   dec_opsel;
    logic [2:0]   dec_op;
    logic         dec_imm_sel;
    logic [S-1:0] dec_rd;
    logic [S-1:0] dec_rs1;
    logic [S-1:0] dec_rs2;
    logic [N-1:0] dec_imm;
    logic         dec_legal;

    // Pipeline tracking
    logic         ex_valid;
    logic [S-1:0] ex_rd;
    logic         wb_valid;
    logic [S-1:0] wb_rd;

    // Register file and writeback path
    logic [N-1:0] regs [NREG];
    logic [N-1:0] wb_data;
    logic         wb_done;
    logic         wb_we;
    logic         alu_carry_unused;

    // Operand and handshake control
    logic [N-1:0] op1;
    logic [N-1:0] op2;
    logic         hazard;
    logic         xfer;
    logic         issue;

    // Field extraction and legality of the presented instruction
    always_comb begin
        dec_opsel   = instr_in[31:29];
        dec_op      = instr_in[28:26];
        dec_imm_sel = instr_in[25];
        dec_rd      = instr_in[24:20];
        dec_rs1     = instr_in[19:15];
        dec_rs2     = instr_in[14:10];
        dec_imm     = {{(N-15){instr_in[14]}}, instr_in[14:0]};
        dec_legal   = (dec_opsel == OPS_ARITH) || (dec_opsel == OPS_MEMRD);
    end

    // The ALU's enable copy is not reset, so it is only trusted together with wb_valid
    always_comb begin
        wb_data          = aluout[N-1:0];
        alu_carry_unused = aluout[N];
        wb_done          = wb_valid && enable_arith_out;
        wb_we            = wb_done && (wb_rd != '0);
    end

    // Hazard check against the instruction in the execute stage; this also gates the handshake
    always_comb begin
        hazard = ex_valid && (ex_rd != '0) &&
                 ((ex_rd == dec_rs1) || (!dec_imm_sel && (ex_rd == dec_rs2)));
        instr_ready = !reset && !hazard;
        xfer        = instr_valid && instr_ready;
        issue       = xfer && dec_legal;
    end

    // Operand 1: a writeback in the same cycle is forwarded in place of the register file read
    always_comb begin
        op1 = regs[dec_rs1];
        if (dec_rs1 == '0) begin
            op1 = '0;
        end else if (wb_we && (wb_rd == dec_rs1)) begin
            op1 = wb_data;
        end
    end

    // Operand 2: the immediate, or a register read with the same forward rule as operand 1
    always_comb begin
        op2 = regs[dec_rs2];
        if (dec_imm_sel) begin
            op2 = dec_imm;
        end else if (dec_rs2 == '0) begin
            op2 = '0;
        end else if (wb_we && (wb_rd == dec_rs2)) begin
            op2 = wb_data;
        end
    end

    // Issue stage: latch ALU inputs on a legal transfer and track the destination down the pipe
    always_ff @(posedge clock) begin
        if (reset) begin
            enable       <= 1'b0;
            aluin1       <= '0;
            aluin2       <= '0;
            aluopselect  <= '0;
            aluoperation <= '0;
            ex_valid     <= 1'b0;
            ex_rd        <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
        end else begin
            enable   <= issue;
            ex_valid <= issue;
            if (issue) begin
                aluin1       <= op1;
                aluin2       <= op2;
                aluopselect  <= dec_opsel;
                aluoperation <= dec_op;
                ex_rd        <= dec_rd;
            end
            wb_valid <= ex_valid;
            wb_rd    <= ex_rd;
        end
    end

    // Register file write from the writeback stage; r0 is never written
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Retire count wraps and includes writes to r0; drop count saturates
    always_ff @(posedge clock) begin
        if (reset) begin
            retire_count <= '0;
            drop_count   <= '0;
        end else begin
            if (wb_done) begin
                retire_count <= retire_count + RCW'(1);
            end
            if (xfer && !dec_legal && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    // Debug read port and status
    always_comb begin
        dbg_rdata = (dbg_raddr == '0) ? '0 : regs[dbg_raddr];
        busy      = ex_valid || wb_valid;
    end

endmodule

// File: tb/tb_alu_issue_wb.sv
// tb_alu_issue_wb: directed scenarios plus randomized traffic for alu_issue_wb.
// An environment ALU registers results one cycle after enable. The reference model
// treats every accepted legal instruction as completing in program order. It keeps an
// architectural register image for the expected operands, and a queue of pending
// writebacks that land two edges after issue. That queue drives the expected debug
// reads, the retire count and busy.
module tb_alu_issue_wb;

    logic               clock = 1'b0;
    logic               reset;
    logic [31:0]        instr_in;
    logic               instr_valid;
    logic               instr_ready;
    logic signed [31:0] aluin1;
    logic signed [31:0] aluin2;
    logic [2:0]         aluopselect;
    logic [2:0]         aluoperation;
    logic               enable;
    logic signed [32:0] aluout = '0;
    logic               enable_arith_out = 1'b0;
    logic [4:0]         dbg_raddr;
    logic [31:0]        dbg_rdata;
    logic [15:0]        retire_count;
    logic [7:0]         drop_count;
    logic               busy;

    alu_issue_wb #(.N(32), .S(5), .NREG(32), .RCW(16)) dut (
        .clock(clock), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .aluin1(aluin1), .aluin2(aluin2),
        .aluopselect(aluopselect), .aluoperation(aluoperation), .enable(enable),
        .aluout(aluout), .enable_arith_out(enable_arith_out), .dbg_raddr(dbg_raddr),
        .dbg_rdata(dbg_rdata), .retire_count(retire_count), .drop_count(drop_count),
        .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic signed [32:0] alu_f(input logic [2:0] sel, input logic [2:0] op,
                                                 input logic [31:0] a, input logic [31:0] b);
        logic signed [32:0] sa, sb;
        sa = {a[31], a};
        sb = {b[31], b};
        if (sel == 3'b101) return sb;
        case (op)
            3'd1:    return sa - sb;
            3'd2:    return sa & sb;
            3'd3:    return sa | sb;
            3'd4:    return sa ^ sb;
            default: return sa + sb;
        endcase
    endfunction

    // Environment ALU: registered result, and an enable copy that is never reset
    always @(posedge clock) begin
        if (enable) aluout <= alu_f(aluopselect, aluoperation, aluin1, aluin2);
        enable_arith_out <= enable;
    end

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] arch [32];
    logic [31:0] comm [32];
    int          edge_n;
    logic        exp_en;
    logic [31:0] exp_in1, exp_in2;
    logic [2:0]  exp_sel, exp_op;
    logic [15:0] exp_ret;
    logic [7:0]  exp_drop;
    logic        prev_iss;
    logic [4:0]  prev_rd;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [2:0] sel, input logic [2:0] op,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [14:0] imm);
        return {sel, op, 1'b1, rd, rs1, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [2:0] sel, input logic [2:0] op,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {sel, op, 1'b0, rd, rs1, rs2, 10'd0};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            arch[i] = '0;
            comm[i] = '0;
        end
        pend.delete();
        exp_en = 1'b0; exp_in1 = '0; exp_in2 = '0; exp_sel = '0; exp_op = '0;
        exp_ret = '0; exp_drop = '0; prev_iss = 1'b0; prev_rd = '0;
    endtask

    // One clock: drive at negedge, check combinational outputs, advance model at posedge, check at next negedge
    task automatic step(input logic rst, input logic vld, input logic [31:0] ins);
        logic               rdy, imm;
        logic [4:0]         rd, rs1, rs2;
        logic [31:0]        o1, o2;
        logic signed [32:0] full;
        pend_t              p;
        reset = rst; instr_valid = vld; instr_in = ins;
        dbg_raddr = 5'($urandom_range(0, 31));
        #1;
        rd = ins[24:20]; rs1 = ins[19:15]; rs2 = ins[14:10]; imm = ins[25];
        rdy = !rst && !(prev_iss && prev_rd != 0 && (rs1 == prev_rd || (!imm && rs2 == prev_rd)));
        chk("instr_ready", {31'd0, instr_ready}, {31'd0, rdy});
        chk("dbg_rdata", dbg_rdata, comm[dbg_raddr]);
        @(posedge clock);
        if (rst) begin
            model_clear();
        end else begin
            while (pend.size() > 0 && pend[0].due == edge_n) begin
                p = pend.pop_front();
                if (p.rd != 0) comm[p.rd] = p.val;
                exp_ret = exp_ret + 16'd1;
            end
            exp_en = 1'b0;
            prev_iss = 1'b0;
            if (vld && rdy) begin
                if (ins[31:29] == 3'b001 || ins[31:29] == 3'b101) begin
                    o1 = arch[rs1];
                    o2 = imm ? {{17{ins[14]}}, ins[14:0]} : arch[rs2];
                    full = alu_f(ins[31:29], ins[28:26], o1, o2);
                    exp_en = 1'b1; exp_in1 = o1; exp_in2 = o2;
                    exp_sel = ins[31:29]; exp_op = ins[28:26];
                    if (rd != 0) arch[rd] = full[31:0];
                    p.rd = rd; p.val = full[31:0]; p.due = edge_n + 2;
                    pend.push_back(p);
                    prev_iss = 1'b1; prev_rd = rd;
                end else if (exp_drop != 8'hFF) begin
                    exp_drop = exp_drop + 8'd1;
                end
            end
        end
        edge_n++;
        @(negedge clock);
        chk("enable", {31'd0, enable}, {31'd0, exp_en});
        if (exp_en) begin
            chk("aluin1", aluin1, exp_in1);
            chk("aluin2", aluin2, exp_in2);
            chk("aluopselect", {29'd0, aluopselect}, {29'd0, exp_sel});
            chk("aluoperation", {29'd0, aluoperation}, {29'd0, exp_op});
        end
        chk("retire_count", {16'd0, retire_count}, {16'd0, exp_ret});
        chk("drop_count", {24'd0, drop_count}, {24'd0, exp_drop});
        chk("busy", {31'd0, busy}, {31'd0, (pend.size() != 0)});
    endtask

    task automatic peek(input string name, input logic [4:0] a, input logic [31:0] e);
        dbg_raddr = a;
        #1;
        chk(name, dbg_rdata, e);
    endtask

    initial begin
        logic [15:0] base;
        logic [2:0]  sel;
        logic [31:0] w;
        edge_n = 0;
        model_clear();
        reset = 1'b1; instr_valid = 1'b0; instr_in = '0; dbg_raddr = '0;
        @(negedge clock);

        // 1: reset, then ADDI r1 = r0 + 5
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_enable", {31'd0, enable}, 32'd0);
        step(1'b0, 1'b1, enc_i(3'b001, 3'b000, 5'd1, 5'd0, 15'd5));
        chk("t1_enable", {31'd0, enable}, 32'd1);
        chk("t1_aluin1", aluin1, 32'd0);
        chk("t1_aluin2", aluin2, 32'd5);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        peek("t1_r1", 5'd1, 32'd5);
        chk("t1_retire", {16'd0, retire_count}, 32'd1);

        // 2: dependent ADD right behind its producer stalls once, then forwards
        step(1'b0, 1'b1, enc_i(3'b001, 3'b000, 5'd1, 5'd0, 15'd5));
        step(1'b0, 1'b1, enc_r(3'b001, 3'b000, 5'd2, 5'd1, 5'd1));
        chk("t2_enable_stall", {31'd0, enable}, 32'd0);
        step(1'b0, 1'b1, enc_r(3'b001, 3'b000, 5'd2, 5'd1, 5'd1));
        chk("t2_aluin1", aluin1, 32'd5);
        chk("t2_aluin2", aluin2, 32'd5);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        peek("t2_r2", 5'd2, 32'd10);

        // 3: three independent instructions issue back to back
        base = retire_count;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, enc_i(3'b001, 3'b000, 5'(3 + i), 5'd0, 15'(1 + i)));
            chk("t3_enable", {31'd0, enable}, 32'd1);
        end
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        chk("t3_retired", {16'd0, retire_count - base}, 32'd3);
        peek("t3_r5", 5'd5, 32'd3);

        // 4: write to r0 counts as retired but r0 stays zero
        base = retire_count;
        step(1'b0, 1'b1, enc_i(3'b001, 3'b000, 5'd0, 5'd0, 15'd7));
        step(1'b0, 1'b1, enc_i(3'b001, 3'b000, 5'd7, 5'd0, 15'd0));
        chk("t4_aluin1", aluin1, 32'd0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        peek("t4_r0", 5'd0, 32'd0);
        chk("t4_retired", {16'd0, retire_count - base}, 32'd2);

        // 5: illegal opselect is accepted and dropped
        step(1'b0, 1'b1, enc_i(3'b000, 3'b000, 5'd9, 5'd0, 15'd1));
        chk("t5_enable", {31'd0, enable}, 32'd0);
        chk("t5_drop", {24'd0, drop_count}, 32'd1);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        peek("t5_r9", 5'd9, 32'd0);

        // 6: immediate sign extension, then reset while an ADD to r6 is in flight
        step(1'b0, 1'b1, enc_i(3'b001, 3'b000, 5'd8, 5'd0, 15'h4000));
        chk("t6_sext", aluin2, 32'hFFFFC000);
        step(1'b0, 1'b1, enc_i(3'b001, 3'b000, 5'd6, 5'd0, 15'd9));
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        peek("t6_r6", 5'd6, 32'd0);
        chk("t6_retire", {16'd0, retire_count}, 32'd0);
        chk("t6_drop", {24'd0, drop_count}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);

        // Drop counter saturation
        for (int i = 0; i < 260; i++) step(1'b0, 1'b1, enc_i(3'b110, 3'b000, 5'd1, 5'd0, 15'd0));
        chk("sat_drop", {24'd0, drop_count}, 32'd255);
        step(1'b1, 1'b0, '0);

        // Randomized traffic on a small register window to provoke hazards and forwarding
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0:       sel = 3'($urandom);
                1, 2:    sel = 3'b101;
                default: sel = 3'b001;
            endcase
            w = {sel, 3'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 15'($urandom)};
            if (w[25] == 1'b0) w[14:10] = 5'($urandom_range(0, 7));
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 4) != 0), w);
        end
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        for (int r = 0; r < 8; r++) peek("final_reg", 5'(r), comm[r]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
